input_fetch_streamer: RTL and testbench
=======================================

// Module: input_fetch_streamer
// PURPOSE
//  Sequencer that sits directly downstream of the combinational input memory. It walks input_sel over one
//  test vector selected by test_sel and registers each returned byte. The bytes go into a small FIFO and
//  stream out with valid/ready to the first neuron layer, so the datapath never sees raw ROM addressing.
// PARAMETERS
//  N_INPUTS    62   bytes per test vector (input_sel runs 0..N_INPUTS-1)
//  N_TESTS     750  number of stored test vectors (valid test_idx 0..N_TESTS-1)
//  DATA_W      8    memory word / stream width
//  SEL_W       32   width of memory select buses
//  FIFO_DEPTH  4    output buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  start          in   1       request to stream one test vector; honoured only in IDLE
//  test_idx       in   SEL_W   test vector number, latched on accepted start
//  abort          in   1       synchronous flush back to IDLE
//  mem_input_sel  out  SEL_W   to memory input_sel
//  mem_test_sel   out  SEL_W   to memory test_sel
//  mem_result     in   DATA_W  from memory result (combinational, same cycle)
//  out_data       out  DATA_W  streamed input byte
//  out_last       out  1       marks byte N_INPUTS-1
//  out_valid      out  1       out_data/out_last valid
//  out_ready      in   1       consumer accepts when out_valid&&out_ready
//  busy           out  1       high in any state except IDLE
//  done           out  1       one-cycle pulse after the last byte has left the FIFO
//  err            out  1       one-cycle pulse when start has test_idx>=N_TESTS
//  checksum       out  16      see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, FIFO empty, mem_*_sel=0, out_valid=0, out_data=0, out_last=0, busy=0,
//   done=0, err=0, checksum=0.
//  FSM IDLE->FETCH on start with test_idx<N_TESTS: latch test_idx into mem_test_sel; idx=0.
//   On start with test_idx>=N_TESTS: err=1 for one cycle, remain IDLE. start outside IDLE is ignored.
//  FETCH: mem_input_sel=idx (combinational from idx).
//   - When FIFO count<FIFO_DEPTH, push {idx==N_INPUTS-1, mem_result} and increment idx.
//   - Otherwise hold idx (stall).
//   - After pushing idx==N_INPUTS-1, go to DRAIN.
//  DRAIN: no pushes; when the FIFO goes empty, go to DONE.
//  DONE: done=1 for exactly one cycle, then IDLE.
//  FIFO:
//   - Push and pop in the same cycle leave count unchanged.
//   - Push is evaluated against the count at the start of the cycle, so a full FIFO refuses a push even
//     when a pop occurs in that cycle.
//   - out_valid = (count!=0). out_data/out_last show the head entry and hold stable while
//     out_valid&&!out_ready.
//  Latency: start accepted in cycle 0 -> FETCH in cycle 1 (first push) -> out_valid=1 in cycle 2.
//   With out_ready held high, one byte per cycle. done is asserted 2 cycles after the last byte is accepted.
//  abort (any state, priority over start): next cycle state=IDLE, FIFO empty, idx=0, out_valid=0.
//   No done pulse; checksum holds its value.
//  rst has priority over abort and start.
//  mem_test_sel holds its last value in IDLE. mem_input_sel = idx in every state.
// CONFIGURATION
//  INPUT_FETCH_CHECKSUM_EN defined:
//   - checksum clears to 0 on an accepted start.
//   - On each push, checksum = checksum + {8'b0, mem_result}, modulo 2^16.
//   - The value is stable from the done pulse until the next accepted start.
//  Not defined: checksum is tied to 16'h0000 and no accumulator logic is built.
// TESTING
//  1 rst=1 for 2 cycles, then idle -> all outputs 0, busy=0.
//  2 start, test_idx=1, out_ready=1 held ->
//    - 62 consecutive out_valid beats whose out_data match the memory at input_sel 0..61;
//    - out_last=1 only on beat 62;
//    - done 2 cycles after beat 62.
//  3 start, test_idx=1, out_ready=0 for 10 cycles then 1 ->
//    - FIFO fills to 4 and idx stalls at 4;
//    - out_data holds byte 0 while stalled;
//    - no byte lost or duplicated over the 62 beats.
//  4 start, test_idx=750 -> err pulse 1 cycle, busy stays 0, no out_valid.
//  5 abort at beat 10 of test_idx=40, then start test_idx=40 -> FIFO flushed; the second run streams
//    bytes 0..61 from the beginning.
//  6 with INPUT_FETCH_CHECKSUM_EN: test_idx=1 -> checksum equals the 16-bit sum of the 62 reference bytes
//    at done; without the macro, checksum==0 throughout.

Source files
------------

// File: rtl/input_fetch_streamer.sv
// input_fetch_streamer: walks the combinational input memory over one test vector,
// buffers each byte in a small FIFO and streams it out with valid/ready.
// Optional feature macro: INPUT_FETCH_CHECKSUM_EN (16-bit running sum of pushed bytes).
module input_fetch_streamer #(
  parameter int unsigned N_INPUTS   = 62,
  parameter int unsigned N_TESTS    = 750,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEL_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  test_idx,
  input  logic              abort,
  output logic [SEL_W-1:0]  mem_input_sel,
  output logic [SEL_W-1:0]  mem_test_sel,
  input  logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       checksum
);

  localparam int unsigned IDX_W = $clog2(N_INPUTS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   test_sel_q, test_sel_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   fifo_d [FIFO_DEPTH];
  logic               err_q, err_d;
  logic               push, pop, start_ok;

  // Handshake qualifiers; push is judged on the count at the start of the cycle
  always_comb begin
    push     = (state_q == S_FETCH) && (count_q < CNT_W'(FIFO_DEPTH));
    pop      = (count_q != '0) && out_ready;
    start_ok = (state_q == S_IDLE) && start && (test_idx < SEL_W'(N_TESTS));
  end

  // Next-state for sequencer, FIFO and error pulse; abort overrides everything but reset
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    test_sel_d = test_sel_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    fifo_d     = fifo_q;
    err_d      = 1'b0;

    if (push) begin
      fifo_d[wr_ptr_q] = {(idx_q == IDX_W'(N_INPUTS - 1)), mem_result};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d    = S_FETCH;
          test_sel_d = test_idx;
          idx_d      = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (push) begin
          if (idx_q == IDX_W'(N_INPUTS - 1)) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      test_sel_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_q     <= '{default: '0};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      test_sel_q <= test_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
      err_q      <= err_d;
    end
  end

`ifdef INPUT_FETCH_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Running sum of pushed bytes; cleared on accepted start, frozen by abort
  always_comb begin
    checksum_d = checksum_q;
    if (start_ok) begin
      checksum_d = '0;
    end else if (push) begin
      checksum_d = checksum_q + 16'(mem_result);
    end
    if (abort) begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  // Output decode, all from registered state
  always_comb begin
    mem_input_sel = SEL_W'(idx_q);
    mem_test_sel  = test_sel_q;
    out_valid     = (count_q != '0);
    {out_last, out_data} = fifo_q[rd_ptr_q];
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    err           = err_q;
  end

endmodule

// File: tb/tb_input_fetch_streamer.sv
// Scoreboard bench for input_fetch_streamer with a behavioural input memory.
module tb_input_fetch_streamer;

  localparam int N_INPUTS = 62;
  localparam int N_TESTS  = 750;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [31:0] test_idx;
  logic [31:0] mem_input_sel, mem_test_sel;
  logic [7:0]  mem_result, out_data;
  logic        out_last, out_valid, busy, done, err;
  logic [15:0] checksum;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_byte(input int t, input int s);
    logic [31:0] v;
    v = 32'(t * 37 + s * 101) + (32'(s * s) ^ 32'(t >> 2));
    return v[7:0];
  endfunction

  assign mem_result = ref_byte(int'(mem_test_sel), int'(mem_input_sel));

  input_fetch_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .test_idx     (test_idx),
    .abort        (abort),
    .mem_input_sel(mem_input_sel),
    .mem_test_sel (mem_test_sel),
    .mem_result   (mem_result),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .checksum     (checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
  endtask

  // Stream one vector; stall = cycles of out_ready low, abort_at = beat count to abort at (-1 none)
  task automatic run_vector(input int tidx, input int stall, input int abort_at);
    int          cyc, beats, first_cyc, last_cyc;
    bit          finished;
    logic [15:0] sum, cs_before;
    beat_t       e;
    sum = '0;
    for (int s = 0; s < N_INPUTS; s++) begin
      e.last = (s == N_INPUTS - 1);
      e.data = ref_byte(tidx, s);
      exp_q.push_back(e);
      sum += 16'(e.data);
    end
    test_idx  = 32'(tidx);
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("test_sel_latched", mem_test_sel, 32'(tidx));
    check("valid_first_fetch", 32'(out_valid), 0);
    cyc = 0; beats = 0; finished = 0; first_cyc = -1; last_cyc = 0;
    while (cyc < 1000 && !finished) begin
      out_ready = (cyc >= stall);
      if (stall > 0 && cyc == stall - 1) begin
        check("stall_idx", mem_input_sel, 32'd4);
        check("stall_valid", 32'(out_valid), 1);
        check("stall_head", 32'(out_data), 32'(exp_q[0].data));
      end
      if (abort_at >= 0 && beats == abort_at) begin
        cs_before = checksum;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("after_abort");
        check("abort_idx", mem_input_sel, 0);
        check("abort_checksum_hold", 32'(checksum), 32'(cs_before));
        exp_q.delete();
        finished = 1;
      end else if (done) begin
        check("beat_count", 32'(beats), 32'(N_INPUTS));
        check("done_gap", 32'(cyc - last_cyc), 2);
        if (stall == 0) check("stream_span", 32'(last_cyc - first_cyc), 32'(N_INPUTS - 1));
`ifdef INPUT_FETCH_CHECKSUM_EN
        check("checksum_at_done", 32'(checksum), 32'(sum));
`else
        check("checksum_tied", 32'(checksum), 0);
`endif
        @(negedge clk);
        check("done_width", 32'(done), 0);
        check("idle_after_done", 32'(busy), 0);
        check("test_sel_hold", mem_test_sel, 32'(tidx));
        finished = 1;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 32'(beats), 32'(N_INPUTS));
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(e.data));
            check("beat_last", 32'(out_last), 32'(e.last));
          end
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
        end
`ifndef INPUT_FETCH_CHECKSUM_EN
        if (checksum !== 16'h0) check("checksum_zero", 32'(checksum), 0);
`endif
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) check("timeout", 32'(cyc), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; test_idx = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_data", 32'(out_data), 0);
    check("reset_last", 32'(out_last), 0);
    check("reset_isel", mem_input_sel, 0);
    check("reset_tsel", mem_test_sel, 0);
    check("reset_checksum", 32'(checksum), 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run_vector(1, 0, -1);
    run_vector(1, 10, -1);

    test_idx = 32'(N_TESTS);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err), 1);
    check("err_busy", 32'(busy), 0);
    check("err_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("err_width", 32'(err), 0);
    check("err_still_idle", 32'(busy), 0);

    run_vector(40, 0, 10);
    @(negedge clk);
    check_idle_outputs("post_abort");
    run_vector(40, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
